cpu_if: RTL and testbench
=========================

Name: cpu_if

Overview:
- Instruction fetch stage; sits directly upstream of the decode stage.
- Owns the PC and drives a req/ack instruction-memory port; the memory may answer in the same cycle or after several cycles.
- Registers {pc, instruction, valid} into the IF/ID pipeline register that decode consumes.
- Handles decode stall, the decode-stage jump redirect and the execute-stage taken-branch redirect, including redirects that arrive while a fetch is still in flight.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INST, 32'h0000_0000: instruction word presented on a bubble.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  decode cannot accept; hold the IF/ID register.
- c_j  in  1  jump (j/jr) resolved in decode this cycle.
- j_target  in  32  jump target address.
- c_b_taken  in  1  taken branch resolved in execute this cycle.
- b_target  in  32  branch target address.
- im_req  out  1  instruction-memory request.
- im_addr  out  32  request address; word aligned.
- im_ack  in  1  request complete; im_rdata valid this cycle; may be asserted in the same cycle im_req rises.
- im_rdata  in  32  instruction word.
- if_pc  out  32  PC of if_inst (registered).
- if_inst  out  32  fetched instruction (registered).
- if_valid  out  1  if_inst is a real instruction, not a bubble (registered).

Behaviour:
- **Reset (async)**
  - pc=RESET_PC, state=REQ, buffer empty.
  - if_pc=0, if_inst=NOP_INST, if_valid=0.
  - Reset mid-transaction abandons that transaction; any late im_ack is not tracked.
- **Redirect**
  - redirect = c_b_taken | c_j; target = c_b_taken ? b_target : j_target. Branch wins because it is the older instruction.
  - target[1:0] is forced to 2'b00.
  - A redirect always has priority over stall.
  - On the redirect edge the IF/ID register takes a bubble: if_valid<=0, if_inst<=NOP_INST, if_pc holds.
- **PC arithmetic**
  - pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- **Request rule**
  - Once im_req is high, im_addr is held stable until im_ack. A request is never withdrawn.
- **State REQ**
  - im_req=1, im_addr=pc.
  - ack & !redirect & !stall: IF/ID <= {pc, im_rdata, 1}; pc<=pc+4; stay in REQ. Throughput is 1 instruction/cycle with a zero-wait memory.
  - ack & !redirect & stall: buffer <= {pc, im_rdata}; pc<=pc+4; go to FULL. IF/ID holds.
  - ack & redirect: discard im_rdata; pc<=target; stay in REQ (new address next cycle).
  - !ack & redirect: drain_addr<=pc; pc<=target; go to DRAIN.
  - !ack & !redirect: stay in REQ. IF/ID holds if stall; otherwise if_valid<=0 (bubble).
- **State FULL**
  - im_req=0.
  - !stall & !redirect: IF/ID <= {buf_pc, buf_inst, 1}; go to REQ.
  - redirect: discard buffer; pc<=target; go to REQ.
  - Otherwise hold.
- **State DRAIN**
  - im_req=1, im_addr=drain_addr.
  - On ack: discard the data; go to REQ.
  - A further redirect while in DRAIN: pc<=new target; stay in DRAIN.
  - if_valid stays 0 in DRAIN unless stall holds the existing IF/ID contents.
- **Simultaneous events**
  - redirect+stall+ack in REQ: behaves as "ack & redirect". Data discarded, bubble written.
- **Latency**
  - Address to IF/ID output = memory latency + 1 edge.
  - Redirect to first target fetch request = next cycle (REQ), or after the drain ack (DRAIN).

Test Plan:
- Reset release, zero-wait memory, no stall → im_addr 0,4,8,… on consecutive cycles. if_pc trails im_addr by one cycle; if_valid=1 from the second cycle.
- Memory with 3-cycle ack latency → im_addr stable for 3 cycles per word. if_valid pulses 1 once per 3 cycles with matching if_pc/if_inst.
- Stall held 4 cycles during an ack at pc=0x10 → IF/ID frozen; im_req=0 while in FULL. On release, if_pc=0x10 with the buffered word, then 0x14 fetch resumes. No word is lost or duplicated.
- c_j with j_target=0x400 while a fetch to 0x20 is pending (ack 2 cycles later) → im_addr holds 0x20 until ack, data discarded, next im_addr=0x400. if_valid=0 throughout.
- c_b_taken (b_target=0x80) and c_j (j_target=0x400) in the same cycle, with stall=1 → next im_addr=0x80; bubble written despite stall.
- RESET_PC=32'hFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000. Async rst asserted mid-DRAIN → outputs return to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/cpu_if.sv
// cpu_if -- instruction fetch stage.
//
// Owns the program counter, issues word fetches on a req/ack instruction
// memory port and loads the IF/ID pipeline register consumed by decode.
// A one-entry buffer keeps a word that arrives while decode is stalled.
// A drain state lets an in-flight request finish after a redirect, so no
// request is ever withdrawn.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   stall              decode cannot accept; hold IF/ID
//   c_j, j_target      jump redirect resolved in decode
//   c_b_taken,b_target taken-branch redirect resolved in execute (wins over c_j)
//   im_req, im_addr    instruction-memory request and word address
//   im_ack, im_rdata   request completion and returned word (same cycle allowed)
//   if_pc, if_inst     IF/ID register: PC and instruction
//   if_valid           IF/ID register holds a real instruction, not a bubble
module cpu_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        c_j,
  input  logic [31:0] j_target,
  input  logic        c_b_taken,
  input  logic [31:0] b_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    S_REQ,    // requesting the word at pc
    S_FULL,   // word buffered while decode stalls; no request
    S_DRAIN   // finishing an abandoned request at drain_addr
  } state_t;

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;

  logic        redirect;
  logic [31:0] target;

  // The branch is the older instruction, so it overrides a same-cycle jump.
  assign redirect = c_b_taken | c_j;
  assign target   = c_b_taken ? {b_target[31:2], 2'b00} : {j_target[31:2], 2'b00};

  // Port outputs decode only registered state, so im_addr cannot move while
  // a request waits for its ack.
  assign im_req  = (state != S_FULL);
  assign im_addr = (state == S_DRAIN) ? drain_addr : pc;

  // NOTE: every register here is written with <= so all updates in this
  // block see the pre-edge values of pc, state and the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC_W;
      drain_addr <= '0;
      buf_pc     <= '0;
      buf_inst   <= '0;
      if_pc      <= '0;
      if_inst    <= NOP_INST;
      if_valid   <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect) begin
            // Redirect beats stall: the wrong-path word (if any) is dropped
            // and a bubble goes to decode.
            pc       <= target;
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            if (!im_ack) begin
              drain_addr <= pc;
              state      <= S_DRAIN;
            end
          end else if (im_ack) begin
            pc <= pc + 32'd4;
            if (stall) begin
              buf_pc   <= pc;
              buf_inst <= im_rdata;
              state    <= S_FULL;
            end else begin
              if_pc    <= pc;
              if_inst  <= im_rdata;
              if_valid <= 1'b1;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
          end
        end

        S_FULL: begin
          if (redirect) begin
            pc       <= target;
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            state    <= S_REQ;
          end else if (!stall) begin
            if_pc    <= buf_pc;
            if_inst  <= buf_inst;
            if_valid <= 1'b1;
            state    <= S_REQ;
          end
        end

        S_DRAIN: begin
          // pc already holds the redirect target; a newer redirect replaces it.
          if (redirect) begin
            pc <= target;
          end
          if (im_ack) begin
            state <= S_REQ;
          end
          if (redirect || !stall) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
          end
        end

        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_if.sv
// tb_cpu_if -- self-checking bench for cpu_if.
//
// A memory model answers requests after a chosen latency. A transaction-level
// reference tracks the next fetch address, an abandoned request being
// drained, a queue of words held back by stall and the expected IF/ID
// contents; DUT outputs are compared against it every cycle.
module tb_cpu_if;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        c_j;
  logic [31:0] j_target;
  logic        c_b_taken;
  logic [31:0] b_target;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  // Second instance: RESET_PC at the top of the address space, zero-wait memory.
  logic        rst_w;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic        w_valid;

  int checks   = 0;
  int failures = 0;

  // Memory model state.
  bit          mem_busy;
  int          mem_cnt;
  int          mem_lat;
  bit          lat_rand;
  int          lat_fix;
  int          lat_max;

  // Reference model state.
  logic [31:0] m_pc;
  bit          m_orphan;
  logic [31:0] m_orphan_addr;
  logic [63:0] m_q[$];
  logic [31:0] m_ifpc;
  logic [31:0] m_ifinst;
  logic        m_ifvalid;

  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign w_rdata = inst_of(w_addr);

  cpu_if #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) u_dut (
    .clk(clk), .rst(rst), .stall(stall),
    .c_j(c_j), .j_target(j_target),
    .c_b_taken(c_b_taken), .b_target(b_target),
    .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_rdata(im_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  cpu_if #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) u_wrap (
    .clk(clk), .rst(rst_w), .stall(1'b0),
    .c_j(1'b0), .j_target(32'h0),
    .c_b_taken(1'b0), .b_target(32'h0),
    .im_req(w_req), .im_addr(w_addr),
    .im_ack(1'b1), .im_rdata(w_rdata),
    .if_pc(w_pc), .if_inst(w_inst), .if_valid(w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0000_0000;
    m_orphan  = 1'b0;
    m_q.delete();
    m_ifpc    = 32'h0;
    m_ifinst  = NOP;
    m_ifvalid = 1'b0;
    mem_busy  = 1'b0;
  endtask

  task automatic model_bubble();
    m_ifvalid = 1'b0;
    m_ifinst  = NOP;
  endtask

  // One clock of the reference, given this cycle's ack and decode/execute inputs.
  task automatic model_step(input logic ack, input logic s, input logic redir,
                            input logic [31:0] tgt_raw);
    logic [31:0] t;
    logic [63:0] e;
    t = {tgt_raw[31:2], 2'b00};
    if (m_orphan) begin
      if (redir) m_pc = t;
      if (ack) m_orphan = 1'b0;
      if (redir || !s) model_bubble();
    end else if (m_q.size() != 0) begin
      if (redir) begin
        m_q.delete();
        m_pc = t;
        model_bubble();
      end else if (!s) begin
        e = m_q.pop_front();
        m_ifpc    = e[63:32];
        m_ifinst  = e[31:0];
        m_ifvalid = 1'b1;
      end
    end else begin
      if (redir) begin
        model_bubble();
        if (!ack) begin
          m_orphan      = 1'b1;
          m_orphan_addr = m_pc;
        end
        m_pc = t;
      end else if (ack) begin
        if (s) begin
          m_q.push_back({m_pc, inst_of(m_pc)});
        end else begin
          m_ifpc    = m_pc;
          m_ifinst  = inst_of(m_pc);
          m_ifvalid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end else if (!s) begin
        model_bubble();
      end
    end
  endtask

  task automatic check_outputs();
    logic exp_req;
    exp_req = (m_q.size() == 0);
    check("im_req", {31'b0, im_req}, {31'b0, exp_req});
    if (exp_req) check("im_addr", im_addr, m_orphan ? m_orphan_addr : m_pc);
    check("if_valid", {31'b0, if_valid}, {31'b0, m_ifvalid});
    check("if_pc", if_pc, m_ifpc);
    check("if_inst", if_inst, m_ifinst);
  endtask

  // Drive one cycle: compare outputs, apply inputs, let the memory answer,
  // advance the reference, then cross the rising edge.
  task automatic step(input logic s, input logic cj, input logic [31:0] jt,
                      input logic cb, input logic [31:0] bt);
    logic ack_now;
    @(negedge clk);
    check_outputs();
    stall     = s;
    c_j       = cj;
    j_target  = jt;
    c_b_taken = cb;
    b_target  = bt;
    if (im_req && !mem_busy) begin
      mem_busy = 1'b1;
      mem_cnt  = 0;
      mem_lat  = lat_rand ? int'($urandom_range(0, lat_max)) : lat_fix;
    end
    ack_now  = im_req && mem_busy && (mem_cnt == mem_lat);
    im_ack   = ack_now;
    im_rdata = ack_now ? inst_of(im_addr) : $urandom;
    model_step(ack_now, s, cj | cb, cb ? bt : jt);
    @(posedge clk);
    #1;
    if (ack_now) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    stall = 1'b0; c_j = 1'b0; j_target = '0; c_b_taken = 1'b0; b_target = '0;
    im_ack = 1'b0; im_rdata = '0;
    lat_rand = 1'b0; lat_fix = 0; lat_max = 0;
    model_reset();

    // PC wrap: 0xFFFF_FFFC is fetched, then 0x0000_0000.
    @(posedge clk); #1;
    rst_w = 1'b0;
    @(negedge clk);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    check("wrap_req", {31'b0, w_req}, 32'd1);
    @(negedge clk);
    check("wrap_addr1", w_addr, 32'h0000_0000);
    check("wrap_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_inst", w_inst, inst_of(32'hFFFF_FFFC));
    check("wrap_valid", {31'b0, w_valid}, 32'd1);

    // Reset values while rst is held.
    @(negedge clk);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, NOP);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_im_req", {31'b0, im_req}, 32'd1);
    check("rst_im_addr", im_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-wait streaming.
    idle(3);
    check("stream_addr", im_addr, 32'h0000_000C);
    check("stream_pc", if_pc, 32'h0000_0008);
    check("stream_valid", {31'b0, if_valid}, 32'd1);

    // Stall held across the ack at 0x10.
    for (int i = 0; i < 20 && m_pc != 32'h10; i++) idle(1);
    check("reach_0x10", im_addr, 32'h10);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("full_no_req", {31'b0, im_req}, 32'd0);
    check("frozen_pc", if_pc, 32'h0C);
    idle(1);
    check("release_pc", if_pc, 32'h10);
    check("release_inst", if_inst, inst_of(32'h10));
    check("resume_addr", im_addr, 32'h14);

    // Three-cycle memory.
    lat_fix = 2;
    idle(9);

    // Jump while the fetch to 0x20 is in flight.
    for (int i = 0; i < 40 && !(m_pc == 32'h20 && m_q.size() == 0 && !mem_busy); i++) idle(1);
    check("pend_addr", im_addr, 32'h20);
    step(1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    check("drain_addr", im_addr, 32'h20);
    idle(2);
    check("jump_addr", im_addr, 32'h400);
    check("jump_valid", {31'b0, if_valid}, 32'd0);

    // Branch and jump together under stall, zero-wait memory.
    lat_fix = 0;
    step(1'b1, 1'b1, 32'h400, 1'b1, 32'h83);
    check("both_addr", im_addr, 32'h80);
    check("both_valid", {31'b0, if_valid}, 32'd0);
    check("both_inst", if_inst, NOP);
    idle(2);

    // Randomized traffic with variable latency.
    lat_rand = 1'b1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 10) < 3, ($urandom % 12) == 0, $urandom,
           ($urandom % 14) == 0, $urandom);
    end
    lat_rand = 1'b0;
    lat_fix  = 3;
    for (int i = 0; i < 60 && (m_orphan || m_q.size() != 0 || mem_busy); i++) idle(1);
    idle(6);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 40 && mem_busy; i++) idle(1);
    step(1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("mid_drain_addr", im_addr, m_orphan_addr);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_if_pc", if_pc, 32'h0);
    check("async_if_inst", if_inst, NOP);
    check("async_if_valid", {31'b0, if_valid}, 32'd0);
    check("async_im_addr", im_addr, 32'h0);
    check("async_im_req", {31'b0, im_req}, 32'd1);
    stall = 1'b0; im_ack = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    lat_fix = 0;
    idle(5);
    check("post_rst_addr", im_addr, 32'h14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
